// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in one
// bit per clock, LSB first, through a single 1-bit full adder.
//
// Handshake: a start pulse is accepted only while idle (busy=0, done=0). The
// operands and carry-in are captured on the accepting edge. busy stays high
// for the WIDTH RUN cycles. done is a one-cycle pulse; sum/cout update on the
// edge that raises done and hold until the next completion. start is ignored
// while busy or done.

module full_adder_single (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;

  // The only adder in the block; it always sees the current LSBs and carry.
  full_adder_single u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign state_dbg = state;

  // Control FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
          psum  <= {fa_s, psum[WIDTH-1:1]};
          carry <= fa_co;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            sum   <= {fa_s, psum[WIDTH-1:1]};
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed additions, latency,
// ignored start, mid-run abort, and a back-to-back random run.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   state_dbg;

  logic [W:0]   exp_q[$];
  int           n_cmp;
  int           n_mis;
  int           done_cnt;
  int           push_cnt;
  logic         prev_done;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // scoreboard: every done pulse pops one expected {cout,sum}
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, e[W]});
      end
    end
    prev_done = rst_n & done;
  end

  // driver: one addition with latency checks; glitch_at>0 pulses a second start mid-run
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int glitch_at);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_add(a, b, c));
    push_cnt++;
    #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      a_in  = W'($urandom_range(0, 255));
      b_in  = W'($urandom_range(0, 255));
      cin   = 1'($urandom_range(0, 1));
      start = (k == glitch_at);
      if (k == glitch_at) begin
        a_in = 8'h01;
        b_in = 8'h01;
      end
      @(posedge clk);
      #1;
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_latency", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("done_cleared", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; done_cnt = 0; push_cnt = 0; prev_done = 1'b0;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // carry chain and carry-in cases
    run_add(8'hFF, 8'h01, 1'b0, 0);
    run_add(8'h3C, 8'h0F, 1'b1, 0);
    run_add(8'hFF, 8'hFF, 1'b1, 0);
    run_add(8'h00, 8'h00, 1'b0, 0);
    run_add(8'hA5, 8'h5A, 1'b1, 0);
    // start during RUN is ignored
    run_add(8'h3C, 8'h0F, 1'b1, 3);
    check("sum_hold_idle", {24'd0, sum}, 32'h4C);

    // mid-run abort at t0+4
    @(negedge clk);
    a_in = 8'h77; b_in = 8'h22; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_add(8'h10, 8'h20, 1'b0, 0);

    // back-to-back: start held, operands change every cycle, accept every W+2
    for (int v = 0; v < 1000; v++) begin
      for (int k = 0; k < W + 2; k++) begin
        @(negedge clk);
        a_in  = W'($urandom_range(0, 255));
        b_in  = W'($urandom_range(0, 255));
        cin   = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(posedge clk);
        if (k == 0) begin
          exp_q.push_back(ref_add(a_in, b_in, cin));
          push_cnt++;
        end
        #1;
        if (k == W) check("b2b_done_period", {31'd0, done}, 32'd1);
        if (k == 0 || k == W - 1) check("b2b_no_done", {31'd0, done}, 32'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);

    check("done_count", done_cnt, push_cnt);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, captured on accepted start.
REQ-006 b_in  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid and updated.
REQ-010 sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
REQ-011 cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 Block SHALL compute a_in+b_in+cin bit-serially, LSB first, using exactly one full_adder_single instance as its only adder.
REQ-013 Internal state: A and B shift registers (WIDTH each), carry flop, partial-sum shift register (WIDTH), bit counter (clog2(WIDTH) bits), FSM.
REQ-014 FSM states SHALL be IDLE, RUN, DONE only.
REQ-015 IDLE, start=1 at edge t0: load A/B regs from a_in/b_in, carry flop from cin, counter=0, go RUN; start=0: stay IDLE.
REQ-016 RUN, each edge: adder inputs are A[0], B[0], carry flop; S shifted into partial-sum MSB; carry flop <= Cout; A/B shift right by 1; counter +1.
REQ-017 RUN edge with counter==WIDTH-1: go DONE; same edge loads sum with final partial-sum value (including this bit) and cout with adder Cout.
REQ-018 DONE: done=1 for exactly that one cycle; next edge goes IDLE unconditionally.
REQ-019 Latency: start accepted at edge t0 -> done high in the cycle following edge t0+WIDTH; busy high between edges t0 and t0+WIDTH.
REQ-020 start SHALL be ignored in RUN and DONE; operands not re-captured; in-progress result unaffected.
REQ-021 start held high continuously SHALL give one addition every WIDTH+2 cycles (next accept at edge t0+WIDTH+2).
REQ-022 sum and cout SHALL change only on the edge entering DONE and hold until next completion; a_in/b_in/cin changes after capture SHALL NOT affect the result.
REQ-023 Carry SHALL propagate across all WIDTH bits; all-ones operands with cin=1 handled without overflow of internal regs.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, A/B/partial-sum regs=0.
REQ-025 Reset during RUN or DONE SHALL abort the operation: no done pulse and no sum/cout update for it.
REQ-026 After rst_n deasserts, first start SHALL be accepted at the first rising edge with start=1.

Verification (WIDTH=8)
REQ-027 Mid-run asynchronous reset: rst_n low between edges -> busy, done, sum, cout read 0 before next edge.
REQ-028 Carry chain: a=0xFF, b=0x01, cin=0, start at t0 -> done in cycle after t0+8, sum=0x00, cout=1.
REQ-029 Carry-in: a=0x3C, b=0x0F, cin=1 -> sum=0x4C, cout=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 Start during RUN: second start with a=0x01, b=0x01 at t0+3 -> ignored; first result (0x3C+0x0F+1 -> 0x4C) unchanged, single done pulse.
REQ-031 Abort: rst_n pulsed low at t0+4 -> no done, outputs 0; following a=0x10, b=0x20, cin=0 -> sum=0x30, cout=0.
REQ-032 Back-to-back: start held high, operands changed each cycle -> done every 10 cycles, each sum/cout equals a+b+cin of the values captured at acceptance; 1000 random vectors checked against reference model.
